// File: rtl/tpu_fp_pkg.sv
// FP32 helpers shared by the TPU post-processing blocks.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package tpu_fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   // Quiet NaN reported for any window that contained a NaN
   localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;

   typedef enum logic {ACCUM, HOLD} pool_state_t;

   // Exponent all ones with a non-zero mantissa; infinities are not NaN
   function automatic logic fp32_is_nan(input logic [31:0] x);
      return (&x[MAN_W+EXP_W-1:MAN_W]) && (|x[MAN_W-1:0]);
   endfunction

endpackage

// File: rtl/maxpool_reducer_if.sv
// Element stream in, pooled result stream out, both valid/ready.
// Latency: n/a (wiring only).
// Backpressure: s_ready / m_ready carry stalls upstream and downstream.
interface maxpool_reducer_if;

   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_nan;

   // The pooling block's view: it consumes elements and produces results
   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_nan
   );

   // The environment's view: it produces elements and consumes results
   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_nan
   );

endinterface

// File: rtl/maxpool_reducer_cmp.sv
// FP32 maximum of two operands using a total-order key; NaN yields canonical NaN.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module fp32_max_cmp
   import tpu_fp_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y,
   output logic        any_nan
);

   logic [31:0] keyA;
   logic [31:0] keyB;

   // Positive values get bit31 set, negatives are inverted, so an unsigned
   // compare of the keys orders the floats; -0 lands just below +0.
   always_comb begin
      keyA    = a[31] ? ~a : (a | 32'h8000_0000);
      keyB    = b[31] ? ~b : (b | 32'h8000_0000);
      any_nan = fp32_is_nan(a) || fp32_is_nan(b);
      if (any_nan) begin
         y = FP32_CANON_NAN;
      end else if (keyA >= keyB) begin
         y = a;
      end else begin
         y = b;
      end
   end

endmodule

// File: rtl/maxpool_reducer.sv
// Reduces each consecutive group of WINDOW FP32 elements to its maximum.
// Latency: result valid the cycle after the last element of a window is accepted.
// Backpressure: a held result blocks input until m_ready; s_ready never depends on s_valid.
module maxpool_reducer
   import tpu_fp_pkg::*;
#(
   parameter  int WINDOW = 4,
   localparam int CNT_W  = $clog2(WINDOW)
) (
   input logic              clk,
   input logic              rst_n,
   maxpool_reducer_if.slave bus
);

   pool_state_t      stateReg;
   logic [CNT_W-1:0] cntReg;
   logic [31:0]      accReg;
   logic             nanSticky;
   logic             mValidReg;
   logic [31:0]      mDataReg;
   logic             mNanReg;

   logic [31:0]      cmpMax;
   logic             cmpNan;
   logic             sReady;
   logic             inXfer;
   logic             outXfer;
   logic             lastElem;
   logic             inNan;

   // Single comparator serves both the running max and the window-final result
   fp32_max_cmp uCmp (
      .a       (accReg),
      .b       (bus.s_data),
      .y       (cmpMax),
      .any_nan (cmpNan)
   );

   // In HOLD the slot frees up exactly when the result leaves, so an element
   // arriving that same cycle can start the next window without a bubble.
   always_comb begin
      sReady   = (stateReg == ACCUM) || bus.m_ready;
      inXfer   = bus.s_valid && sReady;
      outXfer  = mValidReg && bus.m_ready;
      lastElem = (cntReg == CNT_W'(WINDOW - 1));
      inNan    = fp32_is_nan(bus.s_data);
   end

   assign bus.s_ready = sReady;
   assign bus.m_valid = mValidReg;
   assign bus.m_data  = mDataReg;
   assign bus.m_nan   = mNanReg;

   // Window FSM, element counter, running max, NaN sticky and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg  <= ACCUM;
         cntReg    <= '0;
         accReg    <= '0;
         nanSticky <= 1'b0;
         mValidReg <= 1'b0;
         mDataReg  <= '0;
         mNanReg   <= 1'b0;
      end else begin
         if (outXfer) begin
            stateReg  <= ACCUM;
            mValidReg <= 1'b0;
         end
         if (inXfer) begin
            if (cntReg == '0) begin
               // First element seeds the window; nothing stale is compared
               accReg    <= bus.s_data;
               nanSticky <= inNan;
               cntReg    <= CNT_W'(1);
            end else if (lastElem) begin
               mDataReg  <= (nanSticky || inNan) ? FP32_CANON_NAN : cmpMax;
               mNanReg   <= nanSticky || inNan;
               cntReg    <= '0;
               stateReg  <= HOLD;
               mValidReg <= 1'b1;
            end else begin
               accReg    <= cmpMax;
               nanSticky <= nanSticky || cmpNan;
               cntReg    <= cntReg + CNT_W'(1);
            end
         end
      end
   end

endmodule
